// File: rtl/alu_share_arbiter_if.sv
// Request, ALU-drive and response bundle for alu_share_arbiter.
// With ALU_ARB_LOCK_EN defined, the per-requester Lock inputs are added.
interface alu_share_arbiter_if #(
  parameter int unsigned WIDTH = 32
);
  logic             Req0Valid;
  logic             Req1Valid;
  logic             Req0Ready;
  logic             Req1Ready;
  logic [3:0]       Req0Ctl;
  logic [3:0]       Req1Ctl;
  logic [WIDTH-1:0] Req0A;
  logic [WIDTH-1:0] Req0B;
  logic [WIDTH-1:0] Req1A;
  logic [WIDTH-1:0] Req1B;
`ifdef ALU_ARB_LOCK_EN
  logic             Req0Lock;
  logic             Req1Lock;
`endif
  logic [3:0]       ALUctl;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic [WIDTH-1:0] ALUOut;
  logic             Rsp0Valid;
  logic             Rsp1Valid;
  logic             Rsp0Ready;
  logic             Rsp1Ready;
  logic [WIDTH-1:0] RspData;
  logic             RspLessThan;

  // Arbiter side
  modport slave (
`ifdef ALU_ARB_LOCK_EN
    input  Req0Lock, Req1Lock,
`endif
    input  Req0Valid, Req1Valid, Req0Ctl, Req1Ctl, Req0A, Req0B, Req1A, Req1B,
    output Req0Ready, Req1Ready,
    output ALUctl, A, B,
    input  ALUOut,
    output Rsp0Valid, Rsp1Valid, RspData, RspLessThan,
    input  Rsp0Ready, Rsp1Ready
  );

  // Requester / ALU side
  modport master (
`ifdef ALU_ARB_LOCK_EN
    output Req0Lock, Req1Lock,
`endif
    output Req0Valid, Req1Valid, Req0Ctl, Req1Ctl, Req0A, Req0B, Req1A, Req1B,
    input  Req0Ready, Req1Ready,
    input  ALUctl, A, B,
    output ALUOut,
    input  Rsp0Valid, Rsp1Valid, RspData, RspLessThan,
    output Rsp0Ready, Rsp1Ready
  );
endinterface

// File: rtl/alu_share_arbiter.sv
// Round-robin sharing of one ALU between two requesters, IDLE -> EXEC -> RESP.
// Optional ALU_ARB_LOCK_EN: a requester may lock the ALU for atomic op sequences.
module alu_share_arbiter #(
  parameter int unsigned WIDTH = 32
) (
  input logic                clock,
  input logic                reset,
  alu_share_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t state;
  state_t state_nxt;
  logic   last;
  logic   owner;
  logic   grant0;
  logic   grant1;
  logic   allow0;
  logic   allow1;
  logic   v0;
  logic   v1;
  logic   rsp_done;
`ifdef ALU_ARB_LOCK_EN
  logic   lock_held;
  logic   lock_owner;
`endif

  assign rsp_done      = owner ? bus.Rsp1Ready : bus.Rsp0Ready;
  assign bus.Req0Ready = grant0;
  assign bus.Req1Ready = grant1;

  // Grant and next-state; a tie goes to the requester that did not win last
  always_comb begin
    state_nxt = state;
    grant0    = 1'b0;
    grant1    = 1'b0;
    allow0    = 1'b1;
    allow1    = 1'b1;
`ifdef ALU_ARB_LOCK_EN
    if (lock_held) begin
      allow0 = ~lock_owner;
      allow1 = lock_owner;
    end
`endif
    v0 = bus.Req0Valid & allow0;
    v1 = bus.Req1Valid & allow1;
    case (state)
      IDLE: begin
        grant0 = v0 & (~v1 | last);
        grant1 = v1 & (~v0 | ~last);
        if (grant0 | grant1) state_nxt = EXEC;
      end
      EXEC:    state_nxt = RESP;
      RESP:    if (rsp_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // State, ALU drive and response registers
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state           <= IDLE;
      last            <= 1'b1;
      owner           <= 1'b0;
      bus.ALUctl      <= 4'd0;
      bus.A           <= '0;
      bus.B           <= '0;
      bus.RspData     <= '0;
      bus.RspLessThan <= 1'b0;
      bus.Rsp0Valid   <= 1'b0;
      bus.Rsp1Valid   <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
      lock_held       <= 1'b0;
      lock_owner      <= 1'b0;
`endif
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (grant0) begin
            bus.ALUctl <= bus.Req0Ctl;
            bus.A      <= bus.Req0A;
            bus.B      <= bus.Req0B;
            owner      <= 1'b0;
            last       <= 1'b0;
`ifdef ALU_ARB_LOCK_EN
            lock_held  <= bus.Req0Lock;
            lock_owner <= 1'b0;
`endif
          end else if (grant1) begin
            bus.ALUctl <= bus.Req1Ctl;
            bus.A      <= bus.Req1A;
            bus.B      <= bus.Req1B;
            owner      <= 1'b1;
            last       <= 1'b1;
`ifdef ALU_ARB_LOCK_EN
            lock_held  <= bus.Req1Lock;
            lock_owner <= 1'b1;
`endif
          end
        end
        EXEC: begin
          bus.RspData     <= bus.ALUOut;
          bus.RspLessThan <= (bus.ALUOut == WIDTH'(1));
          bus.Rsp0Valid   <= ~owner;
          bus.Rsp1Valid   <= owner;
        end
        RESP: begin
          if (rsp_done) begin
            bus.Rsp0Valid <= 1'b0;
            bus.Rsp1Valid <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
